// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock through a
// ripple chain with a registered carry, under a start/busy/done handshake.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]  chain_s;
  logic              chain_cout;
  logic              carry_msb_in;
  logic [WIDTH-1:0]  digit_ext;
  logic [WIDTH-1:0]  acc_next;

  // Ripple chain over the low DIGIT bits; carry_msb_in ends up as the carry into bit DIGIT-1.
  always_comb begin
    logic c;
    c            = carry_q;
    chain_s      = '0;
    carry_msb_in = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      carry_msb_in = c;
      chain_s[i]   = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    chain_cout = c;
  end

  // Result digits enter from the MSB side so the final step leaves the sum aligned.
  always_comb begin
    digit_ext = WIDTH'(chain_s);
    acc_next  = (acc_q >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chain_cout;
        cnt_d   = cnt_q + 1'b1;
        acc_d   = acc_next;
        if (cnt_q == CntW'(STEPS - 1)) begin
          sum_d   = acc_next;
          cout_d  = chain_cout;
          ovf_d   = carry_msb_in ^ chain_cout;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomised checks of serial_adder_n at WIDTH=8 with DIGIT of 1, 2, 4 and 8.
module tb_serial_adder_n;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       cin_i = 1'b0;
  logic       sub_i = 1'b0;

  logic       busy1, done1, cout1, ovf1;
  logic       busy2, done2, cout2, ovf2;
  logic       busy4, done4, cout4, ovf4;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum1, sum2, sum4, sum8;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .sub_i(sub_i), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1), .ovf_o(ovf1)
  );
  serial_adder_n #(.WIDTH(8), .DIGIT(2)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .sub_i(sub_i), .busy_o(busy2), .done_o(done2), .sum_o(sum2), .cout_o(cout2), .ovf_o(ovf2)
  );
  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .sub_i(sub_i), .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4), .ovf_o(ovf4)
  );
  serial_adder_n #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .sub_i(sub_i), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
  );

  // Present one request for exactly one rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
    @(negedge clk_i);
    a_i = a; b_i = b; cin_i = cin; sub_i = sub; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Wait for the DIGIT=1 instance to finish, counting busy cycles on the way.
  task automatic wait_done1(output int busy_n, output bit ok);
    busy_n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done1) begin
        ok = 1'b1;
        break;
      end
      if (busy1) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_d1: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
               busy1, done1, sum1, cout1, ovf1);
    end
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_d8: got busy=%b done=%b sum=%h, want all zero", busy8, done8, sum8);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_add();
    int n; bit ok;
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done1(n, ok);
    checks++;
    if (!ok || n != 8) begin
      errors++;
      $display("FAIL add_latency: got done=%b busy_cycles=%0d, want done=1 busy_cycles=8", ok, n);
    end
    checks++;
    if ({sum1, cout1, ovf1} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_5a_3c: got sum=%h cout=%b ovf=%b, want 96 0 1", sum1, cout1, ovf1);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL add_busy_in_done: got %b, want 0", busy1);
    end
    @(negedge clk_i);
    checks++;
    if (done1 !== 1'b0 || sum1 !== 8'h96) begin
      errors++;
      $display("FAIL done_pulse: got done=%b sum=%h, want done=0 sum=96", done1, sum1);
    end
  endtask

  task automatic test_add_wrap();
    int n; bit ok;
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done1(n, ok);
    checks++;
    if (!ok || {sum1, cout1, ovf1} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_cin0: got done=%b sum=%h cout=%b ovf=%b, want 00 1 0",
               ok, sum1, cout1, ovf1);
    end
    issue(8'hFF, 8'h01, 1'b1, 1'b0);
    wait_done1(n, ok);
    checks++;
    if (!ok || {sum1, cout1, ovf1} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_cin1: got done=%b sum=%h cout=%b ovf=%b, want 01 1 0",
               ok, sum1, cout1, ovf1);
    end
  endtask

  task automatic test_sub();
    int n; bit ok;
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done1(n, ok);
    checks++;
    if (!ok || {sum1, cout1, ovf1} !== {8'hF0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_10_20: got done=%b sum=%h cout=%b ovf=%b, want F0 0 0",
               ok, sum1, cout1, ovf1);
    end
    // cin=1 must be ignored in subtract mode
    issue(8'h80, 8'h01, 1'b1, 1'b1);
    wait_done1(n, ok);
    checks++;
    if (!ok || {sum1, cout1, ovf1} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_80_01: got done=%b sum=%h cout=%b ovf=%b, want 7F 1 1",
               ok, sum1, cout1, ovf1);
    end
  endtask

  task automatic test_ignore_start();
    int n; bit ok;
    issue(8'h21, 8'h12, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    issue(8'hF0, 8'hF0, 1'b1, 1'b1);
    wait_done1(n, ok);
    checks++;
    if (!ok || {sum1, cout1, ovf1} !== {8'h33, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start: got done=%b sum=%h cout=%b ovf=%b, want 33 0 0",
               ok, sum1, cout1, ovf1);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    @(negedge clk_i);
    a_i = 8'h01; b_i = 8'h02; cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || sum1 !== 8'h03 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got done=%b sum=%h busy=%b, want done=1 sum=03 busy=0",
               ok, sum1, busy1);
    end
    a_i = 8'h40; b_i = 8'h41;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b done=%b, want busy=1 done=0", busy1, done1);
    end
    wait_done1(n, ok);
    checks++;
    if (!ok || n != 7 || {sum1, cout1, ovf1} !== {8'h81, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second: got done=%b busy_rest=%0d sum=%h cout=%b ovf=%b, want 1 7 81 0 1",
               ok, n, sum1, cout1, ovf1);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid_op();
    int n; bit ok;
    issue(8'h33, 8'h44, 1'b0, 1'b0);
    n = 1;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk_i);
      if (busy1) n++;
    end
    checks++;
    if (n != 4 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reach: got busy_cycles=%0d busy=%b, want 4 1", n, busy1);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
               busy1, done1, sum1, cout1, ovf1);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done1(n, ok);
    checks++;
    if (!ok || n != 8 || {sum1, cout1, ovf1} !== {8'h10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_after: got done=%b busy=%0d sum=%h cout=%b ovf=%b, want 1 8 10 0 0",
               ok, n, sum1, cout1, ovf1);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_digit4();
    int n; bit ok;
    issue(8'h9C, 8'h75, 1'b1, 1'b0);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (done4) begin
        ok = 1'b1;
        break;
      end
      if (busy4) n++;
    end
    checks++;
    if (!ok || n != 2 || {sum4, cout4, ovf4} !== {8'h12, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL digit4: got done=%b busy=%0d sum=%h cout=%b ovf=%b, want 1 2 12 1 0",
               ok, n, sum4, cout4, ovf4);
    end
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h12, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL digit8: got sum=%h cout=%b ovf=%b, want 12 1 0", sum8, cout8, ovf8);
    end
    repeat (12) @(negedge clk_i);
  endtask

  task automatic test_random();
    int n; bit ok;
    logic [7:0] a, b, bb, es;
    logic cin, sub, cc, ec, eo;
    logic [8:0] tot;
    for (int v = 0; v < 1000; v++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      bb = sub ? ~b : b;
      cc = sub ? 1'b1 : cin;
      tot = {1'b0, a} + {1'b0, bb} + {8'h00, cc};
      es = tot[7:0];
      ec = tot[8];
      eo = (a[7] == bb[7]) && (es[7] != a[7]);
      issue(a, b, cin, sub);
      wait_done1(n, ok);
      checks++;
      if (!ok || {sum1, cout1, ovf1} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL rnd_d1 a=%h b=%h cin=%b sub=%b: got %h %b %b, want %h %b %b",
                 a, b, cin, sub, sum1, cout1, ovf1, es, ec, eo);
      end
      checks++;
      if ({sum2, cout2, ovf2} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL rnd_d2 a=%h b=%h cin=%b sub=%b: got %h %b %b, want %h %b %b",
                 a, b, cin, sub, sum2, cout2, ovf2, es, ec, eo);
      end
      checks++;
      if ({sum4, cout4, ovf4} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL rnd_d4 a=%h b=%h cin=%b sub=%b: got %h %b %b, want %h %b %b",
                 a, b, cin, sub, sum4, cout4, ovf4, es, ec, eo);
      end
      checks++;
      if ({sum8, cout8, ovf8} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL rnd_d8 a=%h b=%h cin=%b sub=%b: got %h %b %b, want %h %b %b",
                 a, b, cin, sub, sum8, cout8, ovf8, es, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_digit4();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
